// File: rtl/spi_pkg.sv
`default_nettype none
// ============================================================================
// Module   : spi_pkg
// Purpose  : Shared SPI master definitions: FSM state encoding, SPI mode
//            constants ({CPOL,CPHA}) and a counter-width helper.
// Revision : 1.0 - initial release
// ============================================================================
package spi_pkg;

    // Transfer sequencing states of the master controller
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LEAD  = 3'd1,
        XFER  = 3'd2,
        TRAIL = 3'd3,
        DONE  = 3'd4
    } spi_state_e;

    // SPI modes encoded as {CPOL, CPHA}
    localparam logic [1:0] MODE0 = 2'b00;
    localparam logic [1:0] MODE1 = 2'b01;
    localparam logic [1:0] MODE2 = 2'b10;
    localparam logic [1:0] MODE3 = 2'b11;

    // Width of a counter that must hold 0..n-1 (at least one bit)
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/spi_clk_gen.sv
`default_nettype none
// ============================================================================
// Module   : spi_clk_gen
// Purpose  : Half-period timer for the SPI master. Emits a tick at the last
//            clk cycle of every CLK_DIV-cycle half period and classifies the
//            ticks that move SCLK as leading or trailing edges.
// Revision : 1.0 - initial release
// ============================================================================
module spi_clk_gen
    import spi_pkg::*;
#(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en_i,       // a transfer phase is being timed
    input  logic edge_en_i,  // the current tick moves SCLK
    output logic tick_o,
    output logic lead_o,
    output logic trail_o
);

    localparam int unsigned      CNT_W   = cnt_width(CLK_DIV);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             phase_q, phase_d;  // 0: next SCLK edge is a leading edge

    // Tick and edge strobes, plus next-state of the half-period counter
    always_comb begin
        tick_o  = en_i && (cnt_q == CNT_MAX);
        lead_o  = tick_o && edge_en_i && !phase_q;
        trail_o = tick_o && edge_en_i && phase_q;
        cnt_d   = cnt_q;
        phase_d = phase_q;
        if (!en_i) begin
            cnt_d   = '0;
            phase_d = 1'b0;
        end else if (tick_o) begin
            cnt_d = '0;
            if (edge_en_i) begin
                phase_d = !phase_q;
            end
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Counter and edge-phase registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            phase_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/spi_master_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : spi_master_ctrl
// Purpose  : Single-word SPI master with valid/ready CPU side, configurable
//            word size, SCLK divider, mode (CPOL/CPHA) and bit order.
// Revision : 1.0 - initial release
// ============================================================================
module spi_master_ctrl
    import spi_pkg::*;
#(
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned CLK_DIV   = 4,
    parameter bit          CPOL      = 1'b0,
    parameter bit          CPHA      = 1'b0,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              busy,
    output logic              sclk,
    output logic              mosi,
    input  logic              miso,
    output logic              cs_n
);

    // SCLK edges per word; the counter must reach EDGES without wrapping
    localparam int unsigned       EDGES     = 2 * DATA_W;
    localparam int unsigned       EDGE_W    = cnt_width(EDGES + 1);
    localparam logic [EDGE_W-1:0] EDGE_LAST = EDGE_W'(EDGES);

    spi_state_e        state_q, state_d;
    logic [DATA_W-1:0] tx_sr_q, tx_sr_d;
    logic [DATA_W-1:0] rx_sr_q, rx_sr_d;
    logic [DATA_W-1:0] rx_data_q, rx_data_d;
    logic [EDGE_W-1:0] edge_cnt_q, edge_cnt_d;
    logic              sclk_q, sclk_d;

    logic clk_en, edge_en, tick, lead_edge, trail_edge;
    logic sample_edge, shift_edge;

    // SCLK toggles at the start of each XFER half period: the LEAD tick is
    // edge 1 and every XFER tick except the final one is the next edge.
    always_comb begin
        clk_en  = (state_q == LEAD) || (state_q == XFER) || (state_q == TRAIL);
        edge_en = (state_q == LEAD) || ((state_q == XFER) && (edge_cnt_q != EDGE_LAST));
        // CPHA=1 presents bit 0 from LEAD already, so its first leading edge
        // must not shift it away.
        sample_edge = CPHA ? trail_edge : lead_edge;
        shift_edge  = CPHA ? (lead_edge && (edge_cnt_q != '0)) : trail_edge;
    end

    spi_clk_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_clk_gen (
        .clk       (clk),
        .rst_n     (rst_n),
        .en_i      (clk_en),
        .edge_en_i (edge_en),
        .tick_o    (tick),
        .lead_o    (lead_edge),
        .trail_o   (trail_edge)
    );

    // Next-state logic: FSM sequencing, SCLK, shift registers and counters
    always_comb begin
        state_d    = state_q;
        tx_sr_d    = tx_sr_q;
        rx_sr_d    = rx_sr_q;
        rx_data_d  = rx_data_q;
        edge_cnt_d = edge_cnt_q;
        sclk_d     = sclk_q;
        case (state_q)
            IDLE: begin
                sclk_d     = CPOL;
                edge_cnt_d = '0;
                if (tx_valid) begin
                    tx_sr_d = tx_data;
                    rx_sr_d = '0;
                    state_d = LEAD;
                end
            end
            LEAD: begin
                if (tick) state_d = XFER;
            end
            XFER: begin
                if (tick && (edge_cnt_q == EDGE_LAST)) state_d = TRAIL;
            end
            TRAIL: begin
                if (tick) begin
                    rx_data_d = rx_sr_q;  // visible together with rx_valid
                    state_d   = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (lead_edge || trail_edge) begin
            sclk_d     = !sclk_q;
            edge_cnt_d = edge_cnt_q + EDGE_W'(1);
        end
        if (shift_edge) begin
            tx_sr_d = MSB_FIRST ? {tx_sr_q[DATA_W-2:0], 1'b0} : {1'b0, tx_sr_q[DATA_W-1:1]};
        end
        if (sample_edge) begin
            rx_sr_d = MSB_FIRST ? {rx_sr_q[DATA_W-2:0], miso} : {miso, rx_sr_q[DATA_W-1:1]};
        end
    end

    // State registers; reset aborts any transfer and drops the partial word
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            tx_sr_q    <= '0;
            rx_sr_q    <= '0;
            rx_data_q  <= '0;
            edge_cnt_q <= '0;
            sclk_q     <= CPOL;
        end else begin
            state_q    <= state_d;
            tx_sr_q    <= tx_sr_d;
            rx_sr_q    <= rx_sr_d;
            rx_data_q  <= rx_data_d;
            edge_cnt_q <= edge_cnt_d;
            sclk_q     <= sclk_d;
        end
    end

    // Outputs decoded from state so reset forces them immediately
    always_comb begin
        tx_ready = (state_q == IDLE);
        busy     = (state_q != IDLE);
        rx_valid = (state_q == DONE);
        cs_n     = (state_q == IDLE) || (state_q == DONE);
        mosi     = !cs_n && (MSB_FIRST ? tx_sr_q[DATA_W-1] : tx_sr_q[0]);
        sclk     = sclk_q;
        rx_data  = rx_data_q;
    end

endmodule
`default_nettype wire

// File: tb/tb_spi_master_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_spi_master_ctrl
// Purpose  : Self-checking bench for spi_master_ctrl. Three instances cover
//            mode 0 / MSB first, mode 3 / MSB first and mode 1 / LSB first
//            16-bit. An SPI slave model answers on miso and captures mosi.
// Revision : 1.0 - initial release
// ============================================================================
module tb_spi_master_ctrl;
    import spi_pkg::*;

    localparam int NI = 3;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [NI-1:0] tx_valid, tx_ready, rx_valid, busy, sclk, mosi, miso, cs_n;
    logic [NI-1:0] loop_en, s_miso;
    logic [7:0]    txd0, txd1, rxd0, rxd1;
    logic [15:0]   txd2, rxd2;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // Slave model / monitor state per instance
    logic [31:0] s_word [NI];
    logic [31:0] s_cap  [NI];
    logic        s_first[NI];
    logic        sclk_prev[NI], cs_prev[NI];
    int          s_ptr[NI], s_cap_n[NI], s_edges[NI], s_rises[NI];
    int          cs_fall_cyc[NI], rxv_cyc[NI], rxv_cnt[NI];

    // Per-instance configuration
    function automatic int dw(input int j);
        case (j) 0: return 8; 1: return 8; default: return 16; endcase
    endfunction
    function automatic int cd(input int j);
        case (j) 0: return 2; 1: return 3; default: return 1; endcase
    endfunction
    function automatic logic cpol(input int j);
        case (j) 0: return MODE0[1]; 1: return MODE3[1]; default: return MODE1[1]; endcase
    endfunction
    function automatic logic cpha(input int j);
        case (j) 0: return MODE0[0]; 1: return MODE3[0]; default: return MODE1[0]; endcase
    endfunction
    function automatic logic msb(input int j);
        return (j != 2);
    endfunction
    // Word bit carried by serial position p
    function automatic int bidx(input int j, input int p);
        return msb(j) ? (dw(j) - 1 - p) : p;
    endfunction
    function automatic logic [31:0] get_rx(input int j);
        case (j) 0: return {24'd0, rxd0}; 1: return {24'd0, rxd1}; default: return {16'd0, rxd2}; endcase
    endfunction
    task automatic set_tx(input int j, input logic [31:0] v);
        case (j) 0: txd0 = v[7:0]; 1: txd1 = v[7:0]; default: txd2 = v[15:0]; endcase
    endtask

    spi_master_ctrl #(.DATA_W(8), .CLK_DIV(2), .CPOL(MODE0[1]), .CPHA(MODE0[0]), .MSB_FIRST(1'b1)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .tx_data(txd0), .tx_valid(tx_valid[0]), .tx_ready(tx_ready[0]),
        .rx_data(rxd0), .rx_valid(rx_valid[0]), .busy(busy[0]), .sclk(sclk[0]), .mosi(mosi[0]),
        .miso(miso[0]), .cs_n(cs_n[0]));
    spi_master_ctrl #(.DATA_W(8), .CLK_DIV(3), .CPOL(MODE3[1]), .CPHA(MODE3[0]), .MSB_FIRST(1'b1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .tx_data(txd1), .tx_valid(tx_valid[1]), .tx_ready(tx_ready[1]),
        .rx_data(rxd1), .rx_valid(rx_valid[1]), .busy(busy[1]), .sclk(sclk[1]), .mosi(mosi[1]),
        .miso(miso[1]), .cs_n(cs_n[1]));
    spi_master_ctrl #(.DATA_W(16), .CLK_DIV(1), .CPOL(MODE1[1]), .CPHA(MODE1[0]), .MSB_FIRST(1'b0)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .tx_data(txd2), .tx_valid(tx_valid[2]), .tx_ready(tx_ready[2]),
        .rx_data(rxd2), .rx_valid(rx_valid[2]), .busy(busy[2]), .sclk(sclk[2]), .mosi(mosi[2]),
        .miso(miso[2]), .cs_n(cs_n[2]));

    // miso is either a loopback of mosi or the slave model's output
    always_comb begin
        for (int j = 0; j < NI; j++) miso[j] = loop_en[j] ? mosi[j] : s_miso[j];
    end

    always @(posedge clk) cyc <= cyc + 1;

    // SPI slave model: drives miso on drive edges, captures mosi on sample edges
    always @(posedge clk) begin : mon
        logic lead_e;
        #1;
        for (int j = 0; j < NI; j++) begin
            if (cs_prev[j] && !cs_n[j]) begin
                cs_fall_cyc[j] = cyc;
                s_ptr[j] = 0; s_cap[j] = '0; s_cap_n[j] = 0; s_edges[j] = 0; s_rises[j] = 0;
                s_miso[j] = 1'b0;
                if (!cpha(j)) begin
                    s_miso[j] = s_word[j][bidx(j, 0)];
                    s_ptr[j]  = 1;
                end
            end
            if (!cs_n[j] && (sclk[j] !== sclk_prev[j])) begin
                s_edges[j]++;
                if (sclk[j]) s_rises[j]++;
                lead_e = (sclk_prev[j] == cpol(j));
                if (lead_e == !cpha(j)) begin
                    if (s_cap_n[j] == 0) s_first[j] = mosi[j];
                    if (s_cap_n[j] < dw(j)) s_cap[j][bidx(j, s_cap_n[j])] = mosi[j];
                    s_cap_n[j]++;
                end else begin
                    s_miso[j] = (s_ptr[j] < dw(j)) ? s_word[j][bidx(j, s_ptr[j])] : 1'b0;
                    s_ptr[j]++;
                end
            end
            if (cs_n[j]) begin
                checks++;
                if (mosi[j] !== 1'b0 || sclk[j] !== cpol(j)) begin
                    failures++;
                    $display("FAIL idle_lines inst=%0d cyc=%0d mosi=%b sclk=%b exp mosi=0 sclk=%b",
                             j, cyc, mosi[j], sclk[j], cpol(j));
                end
            end
            if (rx_valid[j]) begin
                rxv_cnt[j]++;
                rxv_cyc[j] = cyc;
            end
            sclk_prev[j] = sclk[j];
            cs_prev[j]   = cs_n[j];
        end
    end

    // One word through instance j; optional tx_valid pulse while busy
    task automatic do_xfer(input int j, input logic [31:0] tx_in, input logic [31:0] sw_in,
                           input logic lp, input logic pulse, input string name);
        logic [31:0] mask, tx, sw, exp_rx;
        int n, h, base, exp_lat;
        mask    = 32'hFFFF_FFFF >> (32 - dw(j));
        tx      = tx_in & mask;
        sw      = sw_in & mask;
        exp_rx  = lp ? tx : sw;
        exp_lat = (2 * dw(j) + 2) * cd(j);
        s_word[j]  = sw;
        loop_en[j] = lp;
        n = 0;
        @(negedge clk);
        while (!tx_ready[j] && n < 1000) begin @(negedge clk); n++; end
        checks++;
        if (!tx_ready[j]) begin
            failures++; $display("FAIL %s ready_timeout tx_ready=%b exp=1", name, tx_ready[j]); return;
        end
        base = rxv_cnt[j];
        set_tx(j, tx);
        tx_valid[j] = 1'b1;
        @(posedge clk); #1; h = cyc;
        n = 0;
        @(negedge clk);
        while (!rx_valid[j] && n < 2000) begin
            tx_valid[j] = pulse && (n == 3);
            if (pulse && n == 3) set_tx(j, ~tx);
            @(negedge clk); n++;
        end
        tx_valid[j] = 1'b0;
        checks++;
        if (!rx_valid[j]) begin
            failures++; $display("FAIL %s rx_valid_timeout got=%b exp=1", name, rx_valid[j]); return;
        end
        checks++;
        if (get_rx(j) !== exp_rx) begin
            failures++; $display("FAIL %s rx_data got=%h exp=%h", name, get_rx(j), exp_rx);
        end
        checks++;
        if (s_cap[j] !== tx) begin
            failures++; $display("FAIL %s mosi_word got=%h exp=%h", name, s_cap[j], tx);
        end
        checks++;
        if (cs_fall_cyc[j] !== h || (rxv_cyc[j] - h) !== exp_lat) begin
            failures++;
            $display("FAIL %s latency cs_low_at=%0d rx_valid_after=%0d exp cs_low_at=%0d rx_valid_after=%0d",
                     name, cs_fall_cyc[j], rxv_cyc[j] - h, h, exp_lat);
        end
        checks++;
        if (s_rises[j] !== dw(j) || s_edges[j] !== 2 * dw(j)) begin
            failures++;
            $display("FAIL %s sclk_edges rises=%0d edges=%0d exp rises=%0d edges=%0d",
                     name, s_rises[j], s_edges[j], dw(j), 2 * dw(j));
        end
        @(negedge clk);
        checks++;
        if (rx_valid[j] !== 1'b0 || rxv_cnt[j] !== base + 1 || get_rx(j) !== exp_rx) begin
            failures++;
            $display("FAIL %s strobe_hold rx_valid=%b strobes=%0d rx=%h exp rx_valid=0 strobes=%0d rx=%h",
                     name, rx_valid[j], rxv_cnt[j] - base, get_rx(j), 1, exp_rx);
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        for (int j = 0; j < NI; j++) begin
            checks++;
            if (cs_n[j] !== 1'b1 || sclk[j] !== cpol(j) || mosi[j] !== 1'b0 || rx_valid[j] !== 1'b0 ||
                busy[j] !== 1'b0 || get_rx(j) !== 32'd0) begin
                failures++;
                $display("FAIL reset_state inst=%0d cs_n=%b sclk=%b mosi=%b rx_valid=%b busy=%b rx=%h exp 1,%b,0,0,0,0",
                         j, cs_n[j], sclk[j], mosi[j], rx_valid[j], busy[j], get_rx(j), cpol(j));
            end
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (tx_ready !== 3'b111) begin
            failures++; $display("FAIL reset_release tx_ready got=%b exp=111", tx_ready);
        end
    endtask

    task automatic test_mode0_loopback;
        do_xfer(0, 32'hA5, $urandom, 1'b1, 1'b0, "mode0_loop_A5");
    endtask

    task automatic test_mode3;
        checks++;
        if (sclk[1] !== 1'b1) begin
            failures++; $display("FAIL mode3_idle sclk got=%b exp=1", sclk[1]);
        end
        do_xfer(1, 32'h3C, 32'hFF, 1'b0, 1'b0, "mode3_3C");
    endtask

    task automatic test_lsb16;
        do_xfer(2, 32'h8001, $urandom, 1'b1, 1'b0, "lsb16_8001");
        checks++;
        if (s_first[2] !== 1'b1) begin
            failures++; $display("FAIL lsb16_first_bit got=%b exp=1", s_first[2]);
        end
    endtask

    task automatic test_back_to_back;
        int n, r1, h2;
        loop_en[0] = 1'b1;
        @(negedge clk);
        set_tx(0, 32'h11);
        tx_valid[0] = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        set_tx(0, 32'h22);
        n = 0;
        while (!rx_valid[0] && n < 200) begin @(negedge clk); n++; end
        r1 = cyc;
        checks++;
        if (rx_valid[0] !== 1'b1 || rxd0 !== 8'h11) begin
            failures++; $display("FAIL b2b_first rx_valid=%b rx=%h exp 1/11", rx_valid[0], rxd0);
        end
        @(posedge clk); #1;
        checks++;
        if (tx_ready[0] !== 1'b1 || cs_n[0] !== 1'b1) begin
            failures++; $display("FAIL b2b_idle tx_ready=%b cs_n=%b exp 1/1", tx_ready[0], cs_n[0]);
        end
        @(posedge clk); #1;
        h2 = cyc;
        checks++;
        if (busy[0] !== 1'b1 || cs_n[0] !== 1'b0 || h2 !== r1 + 2) begin
            failures++;
            $display("FAIL b2b_second_accept busy=%b cs_n=%b cyc_after_done=%0d exp 1/0/2",
                     busy[0], cs_n[0], h2 - r1);
        end
        @(negedge clk);
        tx_valid[0] = 1'b0;
        n = 0;
        while (!rx_valid[0] && n < 200) begin @(negedge clk); n++; end
        checks++;
        if (rx_valid[0] !== 1'b1 || rxd0 !== 8'h22 || s_cap[0] !== 32'h22) begin
            failures++;
            $display("FAIL b2b_second rx_valid=%b rx=%h mosi_word=%h exp 1/22/22", rx_valid[0], rxd0, s_cap[0]);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid;
        int n, base;
        base = rxv_cnt[0];
        loop_en[0] = 1'b1;
        @(negedge clk);
        set_tx(0, 32'h96);
        tx_valid[0] = 1'b1;
        @(negedge clk);
        tx_valid[0] = 1'b0;
        n = 0;
        while (s_edges[0] < 4 && n < 500) begin @(negedge clk); n++; end
        checks++;
        if (s_edges[0] !== 4) begin
            failures++; $display("FAIL rst_mid_edge edges=%0d exp=4", s_edges[0]);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (cs_n[0] !== 1'b1 || sclk[0] !== cpol(0) || mosi[0] !== 1'b0 || busy[0] !== 1'b0 ||
            rx_valid[0] !== 1'b0 || rxd0 !== 8'h00) begin
            failures++;
            $display("FAIL rst_mid_async cs_n=%b sclk=%b mosi=%b busy=%b rx_valid=%b rx=%h exp 1/%b/0/0/0/00",
                     cs_n[0], sclk[0], mosi[0], busy[0], rx_valid[0], rxd0, cpol(0));
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (tx_ready[0] !== 1'b1) begin
            failures++; $display("FAIL rst_mid_ready got=%b exp=1", tx_ready[0]);
        end
        repeat (40) @(negedge clk);
        checks++;
        if (rxv_cnt[0] !== base) begin
            failures++; $display("FAIL rst_mid_no_rx strobes=%0d exp=0", rxv_cnt[0] - base);
        end
        do_xfer(0, 32'h5A, $urandom, 1'b1, 1'b0, "rst_mid_5A");
    endtask

    task automatic test_busy_pulse;
        int base;
        for (int j = 0; j < NI; j++) begin
            do_xfer(j, $urandom, $urandom, 1'b0, 1'b1, "busy_pulse");
            base = rxv_cnt[j];
            repeat (3) @(negedge clk);
            checks++;
            if (tx_ready[j] !== 1'b1 || rxv_cnt[j] !== base) begin
                failures++;
                $display("FAIL busy_pulse_ignored inst=%0d tx_ready=%b extra_strobes=%0d exp 1/0",
                         j, tx_ready[j], rxv_cnt[j] - base);
            end
        end
    endtask

    task automatic test_random;
        for (int i = 0; i < 18; i++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            do_xfer(i % NI, $urandom, $urandom, ($urandom_range(0, 3) == 0), 1'b0, "random");
        end
    endtask

    initial begin
        tx_valid = '0;
        loop_en  = '0;
        s_miso   = '0;
        txd0 = '0; txd1 = '0; txd2 = '0;
        for (int j = 0; j < NI; j++) begin
            s_word[j] = '0; s_cap[j] = '0; s_first[j] = 1'b0;
            sclk_prev[j] = cpol(j); cs_prev[j] = 1'b1;
            s_ptr[j] = 0; s_cap_n[j] = 0; s_edges[j] = 0; s_rises[j] = 0;
            cs_fall_cyc[j] = 0; rxv_cyc[j] = 0; rxv_cnt[j] = 0;
        end
        test_reset();
        test_mode0_loopback();
        test_mode3();
        test_lsb16();
        test_back_to_back();
        test_reset_mid();
        test_busy_pulse();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500_000;
        $display("FAIL watchdog simulation did not complete in time");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
